// File: rtl/wrb_port_arbiter.sv
// Writeback port arbiter: buffers one result per execution source and round-robin
// grants up to two of them per cycle onto the two registered register-file write ports.
module wrb_port_arbiter #(
  parameter int REG_SIZE_WIDTH = 6,
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_SRC        = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_i,
  input  logic [NUM_SRC-1:0]                 src_valid_i,
  output logic [NUM_SRC-1:0]                 src_ready_o,
  input  logic [NUM_SRC*REG_SIZE_WIDTH-1:0]  src_addr_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_data_i,
  output logic                               wr_first_valid_o,
  output logic [REG_SIZE_WIDTH-1:0]          wr_first_address_o,
  output logic [DATA_WIDTH-1:0]              wr_first_data_o,
  output logic                               wr_second_valid_o,
  output logic [REG_SIZE_WIDTH-1:0]          wr_second_address_o,
  output logic [DATA_WIDTH-1:0]              wr_second_data_o,
  output logic                               idle_o
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [NUM_SRC-1:0]        slot_valid;
  logic [REG_SIZE_WIDTH-1:0] slot_addr [NUM_SRC];
  logic [DATA_WIDTH-1:0]     slot_data [NUM_SRC];
  ptr_t                      rr_ptr;

  logic                      has_first;
  logic                      has_second;
  ptr_t                      first_idx;
  ptr_t                      second_idx;
  logic [NUM_SRC-1:0]        grant;
  logic [NUM_SRC-1:0]        accept;

  // (base + ofs) mod NUM_SRC, valid for base < NUM_SRC and ofs <= NUM_SRC.
  function automatic ptr_t wrap_add(input ptr_t base, input int unsigned ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    return ptr_t'(sum);
  endfunction

  // Round-robin scan starting at rr_ptr; picks the first two occupied slots.
  always_comb begin
    ptr_t scan_idx;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    has_first  = 1'b0;
    has_second = 1'b0;
    first_idx  = '0;
    second_idx = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      scan_idx = wrap_add(rr_ptr, i);
      if (slot_valid[scan_idx]) begin
        if (!has_first) begin
          has_first = 1'b1;
          first_idx = scan_idx;
        end else if (!has_second) begin
          has_second = 1'b1;
          second_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (has_first)  grant[first_idx]  = 1'b1;
    if (has_second) grant[second_idx] = 1'b1;
  end

  // Grant depends only on slot state, so ready never loops back through src_valid_i.
  assign src_ready_o = {NUM_SRC{!flush_i}} & (~slot_valid | grant);
  assign accept      = src_valid_i & src_ready_o;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      slot_valid <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (accept[k]) begin
          // Writes to physical register 0 complete the handshake but are discarded.
          slot_valid[k] <= |src_addr_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
        end else if (grant[k]) begin
          slot_valid[k] <= 1'b0;
        end
      end
    end
  end

  // NOTE: slot payload storage is not reset; slot_valid alone qualifies it.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (accept[k]) begin
        slot_addr[k] <= src_addr_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
        slot_data[k] <= src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (!flush_i && has_first) begin
      rr_ptr <= wrap_add(has_second ? second_idx : first_idx, 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_first_valid_o    <= 1'b0;
      wr_first_address_o  <= '0;
      wr_first_data_o     <= '0;
      wr_second_valid_o   <= 1'b0;
      wr_second_address_o <= '0;
      wr_second_data_o    <= '0;
    end else if (flush_i) begin
      wr_first_valid_o  <= 1'b0;
      wr_second_valid_o <= 1'b0;
    end else begin
      wr_first_valid_o  <= has_first;
      wr_second_valid_o <= has_second;
      if (has_first) begin
        wr_first_address_o <= slot_addr[first_idx];
        wr_first_data_o    <= slot_data[first_idx];
      end
      if (has_second) begin
        wr_second_address_o <= slot_addr[second_idx];
        wr_second_data_o    <= slot_data[second_idx];
      end
    end
  end

  assign idle_o = ~|slot_valid && !wr_first_valid_o && !wr_second_valid_o;

endmodule

// File: doc/wrb_port_arbiter.md
Name: wrb_port_arbiter

Overview:
- Sits directly upstream of the physical register file write ports.
- Accepts writeback results from six execution sources (alu1, alu2, falu1, falu2, lsu, md) through valid/ready handshakes and holds each in a one-entry per-source slot.
- Round-robin grants up to two slots per cycle onto the two registered write ports consumed by the physical register file.
- Replaces fixed-priority combinational merging: no result is lost when more than two sources complete in the same cycle.

Parameters:
- REG_SIZE_WIDTH, 6, physical register address width.
- DATA_WIDTH, 64, writeback data width.
- NUM_SRC, 6, number of writeback sources. Fixed: index 0 alu1, 1 alu2, 2 falu1, 3 falu2, 4 lsu, 5 md.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  pipeline flush; discards all buffered and in-flight writes.
- src_valid_i  in  NUM_SRC  per-source writeback valid.
- src_ready_o  out  NUM_SRC  per-source slot can accept this cycle.
- src_addr_i  in  NUM_SRC*REG_SIZE_WIDTH  packed destination addresses; source k occupies bits [k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH].
- src_data_i  in  NUM_SRC*DATA_WIDTH  packed writeback data; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- wr_first_valid_o  out  1  write port 0 valid (registered).
- wr_first_address_o  out  REG_SIZE_WIDTH  write port 0 address.
- wr_first_data_o  out  DATA_WIDTH  write port 0 data.
- wr_second_valid_o  out  1  write port 1 valid (registered).
- wr_second_address_o  out  REG_SIZE_WIDTH  write port 1 address.
- wr_second_data_o  out  DATA_WIDTH  write port 1 data.
- idle_o  out  1  high when no slot is occupied and neither output valid is set.

Behaviour:
- Reset (rst=1 at posedge):
  - All slot valids = 0, rr_ptr = 0.
  - wr_first_valid_o = wr_second_valid_o = 0; address and data outputs = 0.
  - idle_o = 1.
  - rst has priority over flush_i and over all handshakes.
- Slot k state: slot_valid[k], slot_addr[k], slot_data[k].
- Ready: src_ready_o[k] = !flush_i && (!slot_valid[k] || grant[k]).
  - grant depends only on slot state and rr_ptr, never on src_valid_i, so there is no combinational loop.
  - A granted slot refills in the same cycle, giving one result per cycle per source.
- Handshake: src_valid_i[k] && src_ready_o[k] at a posedge loads the slot.
  - If src_addr == 0, the handshake completes but the slot stays empty (P0 writes dropped).
  - When a granted slot is reloaded, it stays valid with the new contents.
- Arbitration (combinational, each cycle):
  - Scan slot indices rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - First valid slot found -> port first; second valid slot found -> port second; at most 2 grants.
- Output registers (update every posedge, not reset or flush):
  - wr_first_valid_o <= first grant exists; address/data <= that slot's contents.
  - Same rule for the second port. Address/data hold their previous value when valid is 0.
- Latency: a result accepted at edge E0 is at the earliest driven on a port after E1; the regfile commits it at E2.
- Pointer update: with at least one grant, rr_ptr <= (index of the last granted slot + 1) mod NUM_SRC; with no grant, rr_ptr holds.
  - Guarantees every occupied slot is granted within 3 cycles.
- Flush (flush_i=1 at posedge, rst=0):
  - All slot valids and both output valids cleared; no grants take effect.
  - src_ready_o = 0 throughout the flush cycle.
  - rr_ptr holds.
- No address-conflict detection: distinct renamed destinations are guaranteed upstream. If both ports carry the same address, port second is the later write.
- idle_o is combinational from current state.

Test Plan:
- Reset: assert rst 2 cycles with src_valid_i=6'h3F -> src_ready_o=0x3F is don't-care during reset; after release wr_*_valid_o=0, idle_o=1, rr_ptr=0.
- Single write: source 4 (lsu) addr 5, data 0xDEAD_BEEF accepted at E0 -> after E1 wr_first_valid_o=1, address 5, data 0xDEADBEEF, second valid 0; after E2 both valids 0 and idle_o=1.
- Six-way burst: all sources valid one cycle, addrs 1..6 -> granted in pairs (1,2), (3,4), (5,6) on three consecutive cycles. During that time src_ready_o drops for the waiting slots and rr_ptr ends at 0.
- Sustained per-source throughput: source 0 valid every cycle with incrementing addr 1,2,3,..., others idle -> src_ready_o[0] stays 1 and one write per cycle on port first.
- Round-robin fairness: sources 0, 1 and 5 continuously valid -> no source waits more than 2 cycles between grants; grant order rotates.
- P0 and flush: source 2 with addr 0 -> accepted, no port write. Then fill 4 slots and assert flush_i for one cycle -> next cycle both output valids 0, all slots empty, no stale writes later.
